// File: rtl/mem_access_pkg.sv
// Shared types for the memory stage: pipeline bundle, control word, access size and FSM states.
package mem_access_pkg;

  typedef logic [31:0] rv32i_word;
  typedef logic [4:0]  rv32i_reg;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } mem_size_t;

  typedef struct packed {
    logic      read_b;
    logic      write;
    mem_size_t load_type;
    mem_size_t store_type;
    logic      load_unsigned;
    logic      load_regfile;
  } ctrl_t;

  typedef struct packed {
    logic      valid;
    rv32i_word pc;
    ctrl_t     ctrl;
    rv32i_reg  rd;
    rv32i_word alu;
    rv32i_word rs2;
    rv32i_word mdr;
  } stage_regs;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Size of the access actually issued: stores are sized by store_type, loads by load_type.
  function automatic mem_size_t access_size(input ctrl_t ctrl);
    return ctrl.write ? ctrl.store_type : ctrl.load_type;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory port between the memory stage (master) and the data memory (slave).
interface mem_access_if #(
  parameter int WIDTH = 32
) ();
  logic             read;
  logic             write;
  logic [WIDTH-1:0] address;
  logic [3:0]       wmask;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             resp;

  modport master (output read, write, address, wmask, wdata, input rdata, resp);
  modport slave  (input read, write, address, wmask, wdata, output rdata, resp);
endinterface

// File: rtl/mem_align.sv
// Byte-lane steering for stores and byte/half extraction with sign/zero extension for loads.
module mem_align
  import mem_access_pkg::*;
(
  input  logic       [1:0] offset,
  input  mem_size_t        store_type,
  input  mem_size_t        load_type,
  input  logic             load_unsigned,
  input  rv32i_word        store_data,
  input  rv32i_word        rdata,
  output logic       [3:0] wmask,
  output rv32i_word        wdata,
  output rv32i_word        load_data
);
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Half accesses use only offset[1]; word accesses ignore the offset entirely.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any branch, so no path can infer a latch.
    wmask = 4'b1111;
    wdata = store_data;
    case (store_type)
      MEM_B: begin
        wmask = 4'b0001 << offset;
        wdata = {4{store_data[7:0]}};
      end
      MEM_H: begin
        wmask = 4'b0011 << {offset[1], 1'b0};
        wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte   = rdata[{offset, 3'b000} +: 8];
    ld_half   = rdata[{offset[1], 4'b0000} +: 16];
    load_data = rdata;
    case (load_type)
      MEM_B: load_data = load_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      MEM_H: load_data = load_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory stage: issues loads/stores on the data port and forwards the execute bundle to writeback.
// Define MEM_MISALIGN_CHECK_EN to trap misaligned half/word accesses instead of truncating the offset.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  stage_regs    regs_in,
  input  logic         stall_in,
  output logic         stall_out,
  mem_access_if.master mem,
  output stage_regs    regs_out,
  output logic         misalign
);
  state_t           state_q, state_d;
  logic             read_q, write_q;
  logic [WIDTH-1:0] address_q, wdata_q;
  logic [3:0]       wmask_q;
  rv32i_word        hold_mdr_q;

  logic             mem_op, misaligned, mem_req, mis_pass;
  logic [3:0]       store_mask;
  rv32i_word        store_data, load_data, resp_mdr;
  stage_regs        pass_regs, done_regs;

  assign mem_op = regs_in.valid & (regs_in.ctrl.read_b | regs_in.ctrl.write);

`ifdef MEM_MISALIGN_CHECK_EN
  always_comb begin
    case (access_size(regs_in.ctrl))
      MEM_B:   misaligned = 1'b0;
      MEM_H:   misaligned = regs_in.alu[0];
      default: misaligned = |regs_in.alu[1:0];
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  assign mem_req  = mem_op & ~misaligned;
  assign mis_pass = mem_op & misaligned;

  // regs_in is held upstream for the whole access, so one aligner serves request and response.
  mem_align u_align (
    .offset        (regs_in.alu[1:0]),
    .store_type    (regs_in.ctrl.store_type),
    .load_type     (regs_in.ctrl.load_type),
    .load_unsigned (regs_in.ctrl.load_unsigned),
    .store_data    (regs_in.rs2),
    .rdata         (mem.rdata),
    .wmask         (store_mask),
    .wdata         (store_data),
    .load_data     (load_data)
  );

  assign resp_mdr = regs_in.ctrl.read_b ? load_data : '0;

  always_comb begin
    pass_regs     = regs_in;
    pass_regs.mdr = '0;
    if (mis_pass) pass_regs.ctrl.load_regfile = 1'b0;
    done_regs     = regs_in;
    done_regs.mdr = (state_q == HOLD) ? hold_mdr_q : resp_mdr;
  end

  always_comb begin
    state_d   = state_q;
    stall_out = stall_in;
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          state_d   = ACCESS;
          stall_out = 1'b1;
        end
      end
      ACCESS: begin
        stall_out = 1'b1;
        if (mem.resp) state_d = stall_in ? HOLD : IDLE;
      end
      HOLD: begin
        stall_out = 1'b1;
        if (!stall_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem.read    = read_q;
  assign mem.write   = write_q;
  assign mem.address = address_q;
  assign mem.wmask   = wmask_q;
  assign mem.wdata   = wdata_q;

  // While waiting on memory, writeback gets a bubble so the previous bundle is not retired twice.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state_q    <= IDLE;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      address_q  <= '0;
      wmask_q    <= '0;
      wdata_q    <= '0;
      hold_mdr_q <= '0;
      regs_out   <= '0;
      misalign   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (mem_req) begin
            read_q    <= regs_in.ctrl.read_b;
            write_q   <= regs_in.ctrl.write;
            address_q <= {regs_in.alu[WIDTH-1:2], 2'b00};
            wmask_q   <= regs_in.ctrl.write ? store_mask : 4'b0000;
            wdata_q   <= store_data;
          end
          if (!stall_in) begin
            regs_out <= mem_req ? '0 : pass_regs;
            misalign <= mis_pass;
          end
        end
        ACCESS: begin
          if (mem.resp) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            if (stall_in) begin
              hold_mdr_q <= resp_mdr;
            end else begin
              regs_out <= done_regs;
              misalign <= 1'b0;
            end
          end else if (!stall_in) begin
            regs_out <= '0;
            misalign <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall_in) begin
            regs_out <= done_regs;
            misalign <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed corner cases plus randomized traffic against a transaction-level model.
module tb_mem_access;
  import mem_access_pkg::*;

  logic      clk;
  logic      reset;
  stage_regs regs_in, regs_out;
  logic      stall_in, stall_out, misalign;
  int        n_tests = 0;
  int        n_fail  = 0;

  mem_access_if mem ();

  mem_access #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .regs_in   (regs_in),
    .stall_in  (stall_in),
    .stall_out (stall_out),
    .mem       (mem),
    .regs_out  (regs_out),
    .misalign  (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic model_is_mem(input stage_regs r);
    return r.valid && (r.ctrl.read_b || r.ctrl.write);
  endfunction

  function automatic logic model_misaligned(input stage_regs r);
`ifdef MEM_MISALIGN_CHECK_EN
    int unsigned off;
    mem_size_t   sz;
    off = 32'(r.alu[1:0]);
    sz  = r.ctrl.write ? r.ctrl.store_type : r.ctrl.load_type;
    if (sz == MEM_H) return (off % 2) != 0;
    if (sz == MEM_W) return off != 0;
    return 1'b0;
`else
    return r.alu[0] && 1'b0;
`endif
  endfunction

  function automatic logic [3:0] model_mask(input stage_regs r);
    int unsigned off;
    off = 32'(r.alu[1:0]);
    case (r.ctrl.store_type)
      MEM_B:   return 4'(1 << off);
      MEM_H:   return 4'(3 << (off & 2));
      default: return 4'hF;
    endcase
  endfunction

  function automatic rv32i_word model_wdata(input stage_regs r);
    case (r.ctrl.store_type)
      MEM_B:   return 32'(r.rs2[7:0]) * 32'h0101_0101;
      MEM_H:   return 32'(r.rs2[15:0]) * 32'h0001_0001;
      default: return r.rs2;
    endcase
  endfunction

  function automatic rv32i_word model_mdr(input stage_regs r, input rv32i_word rdata);
    int unsigned off;
    longint      v;
    off = 32'(r.alu[1:0]);
    case (r.ctrl.load_type)
      MEM_B: begin
        v = 64'((rdata >> (8 * off)) & 32'hFF);
        if (!r.ctrl.load_unsigned && v >= 128) v = v - 256;
      end
      MEM_H: begin
        v = 64'((rdata >> (8 * (off & 2))) & 32'hFFFF);
        if (!r.ctrl.load_unsigned && v >= 32768) v = v - 65536;
      end
      default: v = 64'(rdata);
    endcase
    return rv32i_word'(v);
  endfunction

  function automatic stage_regs make_txn(input logic rd_op, input logic wr_op, input mem_size_t sz,
                                         input logic uns, input rv32i_word alu, input rv32i_word rs2);
    stage_regs r;
    r                    = '0;
    r.valid              = 1'b1;
    r.pc                 = 32'h0000_4000;
    r.rd                 = 5'd7;
    r.ctrl.read_b        = rd_op;
    r.ctrl.write         = wr_op;
    r.ctrl.load_type     = sz;
    r.ctrl.store_type    = sz;
    r.ctrl.load_unsigned = uns;
    r.ctrl.load_regfile  = rd_op;
    r.alu                = alu;
    r.rs2                = rs2;
    return r;
  endfunction

  function automatic stage_regs rand_txn(input int kind);
    stage_regs r;
    r = make_txn(kind == 1, kind == 2, mem_size_t'(2'($urandom_range(0, 2))),
                 1'($urandom_range(0, 1)), $urandom, $urandom);
    r.pc = $urandom;
    r.rd = 5'($urandom);
    if (kind != 0 && $urandom_range(0, 1) == 1) r.alu[1:0] = 2'b00;
    if (kind == 0) begin
      r.valid             = 1'($urandom_range(0, 1));
      r.ctrl.load_regfile = 1'($urandom_range(0, 1));
      if (!r.valid) begin
        r.ctrl.read_b = 1'($urandom_range(0, 1));
        r.ctrl.write  = 1'($urandom_range(0, 1));
      end
    end
    return r;
  endfunction

  // Acts as upstream stage and data memory for one transaction; starts and ends on a falling edge.
  task automatic run_txn(input stage_regs t, input rv32i_word rdata, input int resp_delay, input int hold_cycles,
                         output int read_cycles, output rv32i_word obs_addr,
                         output logic [3:0] obs_mask, output rv32i_word obs_wdata);
    stage_regs exp, snap;
    logic      mis;
    rv32i_word exp_addr;
    read_cycles = 0;
    obs_addr    = '0;
    obs_mask    = '0;
    obs_wdata   = '0;
    snap        = regs_out;
    mis         = model_misaligned(t);
    exp         = t;
    exp.mdr     = '0;
    exp_addr    = {t.alu[31:2], 2'b00};
    regs_in     = t;
    stall_in    = 1'b0;
    mem.resp    = 1'b0;

    if (!model_is_mem(t) || mis) begin
      mem.resp  = 1'($urandom_range(0, 1));
      mem.rdata = $urandom;
      if (mis) exp.ctrl.load_regfile = 1'b0;
      #1;
      if (!mis) check("pass_stall", 160'(stall_out), 160'(1'b0));
      @(negedge clk);
      mem.resp = 1'b0;
      check("pass_regs", 160'(regs_out), 160'(exp));
      check("pass_misalign", 160'(misalign), 160'(mis));
      check("pass_no_req", 160'({mem.read, mem.write}), 160'(2'b00));
      regs_in = '0;
      return;
    end

    @(negedge clk);
    obs_addr  = mem.address;
    obs_mask  = mem.wmask;
    obs_wdata = mem.wdata;
    check("req_addr", 160'(mem.address), 160'(exp_addr));
    if (t.ctrl.write) begin
      check("req_wmask", 160'(mem.wmask), 160'(model_mask(t)));
      check("req_wdata", 160'(mem.wdata), 160'(model_wdata(t)));
    end
    for (int i = 0; i <= resp_delay; i++) begin
      check("req_held", 160'({mem.read, mem.write, mem.address}), 160'({t.ctrl.read_b, t.ctrl.write, exp_addr}));
      check("stall_access", 160'(stall_out), 160'(1'b1));
      read_cycles += int'(mem.read);
      if (i == resp_delay) begin
        stall_in  = (hold_cycles > 0);
        mem.resp  = 1'b1;
        mem.rdata = rdata;
        snap      = regs_out;
      end else begin
        stall_in  = 1'($urandom_range(0, 1));
        mem.rdata = $urandom;
      end
      @(negedge clk);
    end
    mem.resp  = 1'b0;
    mem.rdata = $urandom;
    if (t.ctrl.read_b) exp.mdr = model_mdr(t, rdata);

    for (int i = 0; i < hold_cycles; i++) begin
      check("hold_regs", 160'(regs_out), 160'(snap));
      check("hold_stall", 160'(stall_out), 160'(1'b1));
      check("hold_no_req", 160'({mem.read, mem.write}), 160'(2'b00));
      stall_in = (i != hold_cycles - 1);
      @(negedge clk);
    end
    check("done_regs", 160'(regs_out), 160'(exp));
    check("done_no_req", 160'({mem.read, mem.write}), 160'(2'b00));
    check("done_misalign", 160'(misalign), 160'(1'b0));
    regs_in = '0;
    #1;
    check("done_stall_release", 160'(stall_out), 160'(1'b0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    stage_regs  t, snap;
    int         rc;
    rv32i_word  oa, ow;
    logic [3:0] om;

    reset     = 1'b0;
    regs_in   = '0;
    stall_in  = 1'b0;
    mem.resp  = 1'b0;
    mem.rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_regs_out", 160'(regs_out), 160'(0));
    check("rst_misalign", 160'(misalign), 160'(1'b0));
    check("rst_req", 160'({mem.read, mem.write, mem.wmask}), 160'(0));
    check("rst_addr_data", 160'({mem.address, mem.wdata}), 160'(0));
    check("rst_stall", 160'(stall_out), 160'(1'b0));
    reset = 1'b1;
    @(negedge clk);

    // lw at 0x100, response in the third request cycle
    t = make_txn(1'b1, 1'b0, MEM_W, 1'b0, 32'h100, 32'h0);
    run_txn(t, 32'hDEAD_BEEF, 2, 0, rc, oa, om, ow);
    check("lw_read_cycles", 160'(rc), 160'(3));
    check("lw_mdr", 160'(regs_out.mdr), 160'(32'hDEAD_BEEF));

    // lb / lbu at 0x103
    t = make_txn(1'b1, 1'b0, MEM_B, 1'b0, 32'h103, 32'h0);
    run_txn(t, 32'h8011_2233, 0, 0, rc, oa, om, ow);
    check("lb_mdr", 160'(regs_out.mdr), 160'(32'hFFFF_FF80));
    t = make_txn(1'b1, 1'b0, MEM_B, 1'b1, 32'h103, 32'h0);
    run_txn(t, 32'h8011_2233, 1, 0, rc, oa, om, ow);
    check("lbu_mdr", 160'(regs_out.mdr), 160'(32'h0000_0080));

    // sh at 0x202
    t = make_txn(1'b0, 1'b1, MEM_H, 1'b0, 32'h202, 32'h1234_ABCD);
    run_txn(t, 32'h0, 1, 0, rc, oa, om, ow);
    check("sh_addr", 160'(oa), 160'(32'h200));
    check("sh_wmask", 160'(om), 160'(4'b1100));
    check("sh_wdata", 160'(ow), 160'(32'hABCD_ABCD));
    check("sh_mdr", 160'(regs_out.mdr), 160'(0));

    // response while writeback is stalled
    t = make_txn(1'b1, 1'b0, MEM_H, 1'b0, 32'h412, 32'h0);
    run_txn(t, 32'h9abc_5678, 1, 3, rc, oa, om, ow);
    check("hold_mdr", 160'(regs_out.mdr), 160'(32'hFFFF_9ABC));

    // reset in the middle of an access, then a stray response
    t = make_txn(1'b1, 1'b0, MEM_W, 1'b0, 32'h300, 32'h0);
    regs_in = t;
    @(negedge clk);
    check("rst_mid_req", 160'(mem.read), 160'(1'b1));
    reset = 1'b0;
    @(negedge clk);
    reset            = 1'b1;
    check("rst_mid_req_drop", 160'({mem.read, mem.write, mem.address, mem.wmask}), 160'(0));
    regs_in          = make_txn(1'b0, 1'b0, MEM_W, 1'b0, 32'h55, 32'h66);
    stall_in         = 1'b1;
    mem.resp         = 1'b1;
    mem.rdata        = 32'h1357_9BDF;
    @(negedge clk);
    mem.resp = 1'b0;
    check("rst_mid_regs_out", 160'(regs_out), 160'(0));
    check("rst_mid_outputs", 160'({misalign, mem.read, mem.write, mem.address, mem.wmask, mem.wdata}), 160'(0));
    regs_in  = '0;
    stall_in = 1'b0;
    #1;
    check("rst_mid_idle", 160'(stall_out), 160'(1'b0));
    @(negedge clk);

`ifdef MEM_MISALIGN_CHECK_EN
    t = make_txn(1'b1, 1'b0, MEM_W, 1'b0, 32'h101, 32'h0);
    run_txn(t, 32'h0, 0, 0, rc, oa, om, ow);
    check("mis_flag", 160'(misalign), 160'(1'b1));
    check("mis_no_regfile", 160'(regs_out.ctrl.load_regfile), 160'(1'b0));
    @(negedge clk);
    check("mis_one_cycle", 160'(misalign), 160'(1'b0));
`else
    t = make_txn(1'b1, 1'b0, MEM_W, 1'b0, 32'h101, 32'h0);
    run_txn(t, 32'hCAFE_F00D, 0, 0, rc, oa, om, ow);
    check("trunc_lw_addr", 160'(oa), 160'(32'h100));
    check("trunc_lw_mdr", 160'(regs_out.mdr), 160'(32'hCAFE_F00D));
    t = make_txn(1'b0, 1'b1, MEM_H, 1'b0, 32'h203, 32'h1234_ABCD);
    run_txn(t, 32'h0, 0, 0, rc, oa, om, ow);
    check("trunc_sh_wmask", 160'(om), 160'(4'b1100));
    check("trunc_misalign", 160'(misalign), 160'(1'b0));
`endif

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      int kind;
      kind = int'($urandom_range(0, 2));
      t    = rand_txn(kind);
      if (kind == 0 && $urandom_range(0, 3) == 0) begin
        snap     = regs_out;
        regs_in  = t;
        stall_in = 1'b1;
        @(negedge clk);
        check("idle_stall_hold", 160'(regs_out), 160'(snap));
      end
      run_txn(t, $urandom, int'($urandom_range(0, 3)),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, rc, oa, om, ow);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
